mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_if.sv | 22 ++
 rtl/mem_arb.sv | 152 +++++++++++++++
 tb/tb_mem_arb.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Memory-side bus between the arbiter (master) and the memory slave.
// One request outstanding at a time: address phase, then data phase.
interface mem_arb_if;
  logic        m_req;
  logic        m_wr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;

  modport master (
    output m_req, m_wr, m_wstrb, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  modport slave (
    input  m_req, m_wr, m_wstrb, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );
endinterface

// File: rtl/mem_arb.sv
// Two-port (instruction fetch / data) arbiter onto a single memory bus.
// Round-robin on contention; flush cancels fetch traffic only.
module mem_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [3:0]  d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  input  logic        flush,
  mem_arb_if.master   mem,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        cancel_q, cancel_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;

  logic d_elig, i_elig, i_flush;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cancel_d     = cancel_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;

    d_elig  = d_req & ~d_done_q;
    i_elig  = i_req & ~i_done_q & ~flush;
    i_flush = (owner_q == OWN_I) & flush;

    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        // D wins when alone, or on contention when I was served last
        if (d_elig && (!i_elig || last_owner_q == OWN_I)) begin
          state_d      = ADDR;
          owner_d      = OWN_D;
          last_owner_d = OWN_D;
          addr_d       = d_addr;
          wr_d         = d_wr;
          wstrb_d      = d_wen;
          wdata_d      = d_wdata;
        end else if (i_elig) begin
          state_d      = ADDR;
          owner_d      = OWN_I;
          last_owner_d = OWN_I;
          addr_d       = i_addr;
          wr_d         = 1'b0;
          wstrb_d      = '0;
          wdata_d      = '0;
        end
      end
      ADDR: begin
        if (mem.m_addr_ok) begin
          state_d = DATA;
          if (i_flush) cancel_d = 1'b1;
        end else if (i_flush) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (i_flush) cancel_d = 1'b1;
        if (mem.m_data_ok) begin
          state_d  = IDLE;
          cancel_d = 1'b0;
          if (owner_q == OWN_D) begin
            d_done_d = 1'b1;
            if (!wr_q) d_rdata_d = mem.m_rdata;
          end else if (!(cancel_q || flush)) begin
            i_done_d  = 1'b1;
            i_rdata_d = mem.m_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      cancel_q     <= 1'b0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cancel_q     <= cancel_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
    end
  end

  assign mem.m_req   = (state_q == ADDR);
  assign mem.m_wr    = wr_q;
  assign mem.m_wstrb = wstrb_q;
  assign mem.m_addr  = addr_q;
  assign mem.m_wdata = wdata_q;

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: the bench plays the CPU and the memory slave,
// driving inputs and checking outputs 1 ns after each rising edge.
module tb_mem_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [3:0]  d_wen = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        flush = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_arb_if mem ();

  mem_arb u_dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_done  (i_done),
    .d_req   (d_req),
    .d_wr    (d_wr),
    .d_wen   (d_wen),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .flush   (flush),
    .mem     (mem),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    mem.m_addr_ok = 1'b0;
    mem.m_data_ok = 1'b0;
    mem.m_rdata   = '0;

    // Reset state
    #3;
    chk("rst_m_req", {31'd0, mem.m_req}, 32'd0);
    chk("rst_m_addr", mem.m_addr, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    step();
    rst = 1'b1;
    step();

    // Single fetch read, minimum latency
    i_req = 1'b1; i_addr = 32'hBFC00000;
    step();
    chk("rd_m_req", {31'd0, mem.m_req}, 32'd1);
    chk("rd_m_addr", mem.m_addr, 32'hBFC00000);
    chk("rd_m_wr", {31'd0, mem.m_wr}, 32'd0);
    chk("rd_busy", {31'd0, busy}, 32'd1);
    mem.m_addr_ok = 1'b1;
    step();
    chk("rd_m_req_drop", {31'd0, mem.m_req}, 32'd0);
    chk("rd_no_done_early", {31'd0, i_done}, 32'd0);
    mem.m_addr_ok = 1'b0; mem.m_data_ok = 1'b1; mem.m_rdata = 32'h24080001;
    step();
    chk("rd_i_done", {31'd0, i_done}, 32'd1);
    chk("rd_i_rdata", i_rdata, 32'h24080001);
    chk("rd_busy_idle", {31'd0, busy}, 32'd0);
    mem.m_data_ok = 1'b0; i_req = 1'b0;
    step();
    chk("rd_i_done_pulse", {31'd0, i_done}, 32'd0);

    // Contention from reset: D first, then I in D's done cycle
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h00000100;
    d_req = 1'b1; d_addr = 32'h00000200; d_wr = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("arb_first_addr", mem.m_addr, 32'h00000200);
    mem.m_addr_ok = 1'b1;
    step();
    mem.m_addr_ok = 1'b0; mem.m_data_ok = 1'b1; mem.m_rdata = 32'hAAAA5555;
    step();
    chk("arb_d_done", {31'd0, d_done}, 32'd1);
    chk("arb_d_rdata", d_rdata, 32'hAAAA5555);
    chk("arb_i_not_done", {31'd0, i_done}, 32'd0);
    mem.m_data_ok = 1'b0; d_req = 1'b0;
    step();
    chk("arb_second_req", {31'd0, mem.m_req}, 32'd1);
    chk("arb_second_addr", mem.m_addr, 32'h00000100);
    chk("arb_d_done_pulse", {31'd0, d_done}, 32'd0);
    mem.m_addr_ok = 1'b1;
    step();
    mem.m_addr_ok = 1'b0; mem.m_data_ok = 1'b1; mem.m_rdata = 32'h11112222;
    step();
    chk("arb_i_done", {31'd0, i_done}, 32'd1);
    chk("arb_i_rdata", i_rdata, 32'h11112222);
    chk("arb_d_rdata_kept", d_rdata, 32'hAAAA5555);
    mem.m_data_ok = 1'b0; i_req = 1'b0;
    step();
    chk("arb_idle", {31'd0, busy}, 32'd0);

    // Data write
    d_req = 1'b1; d_wr = 1'b1; d_wen = 4'b0011;
    d_wdata = 32'h0000BEEF; d_addr = 32'h80000010;
    step();
    chk("wr_m_req", {31'd0, mem.m_req}, 32'd1);
    chk("wr_m_wr", {31'd0, mem.m_wr}, 32'd1);
    chk("wr_m_wstrb", {28'd0, mem.m_wstrb}, 32'h3);
    chk("wr_m_wdata", mem.m_wdata, 32'h0000BEEF);
    chk("wr_m_addr", mem.m_addr, 32'h80000010);
    mem.m_addr_ok = 1'b1;
    step();
    mem.m_addr_ok = 1'b0; mem.m_data_ok = 1'b1; mem.m_rdata = 32'hDEADDEAD;
    step();
    chk("wr_d_done", {31'd0, d_done}, 32'd1);
    chk("wr_d_rdata_kept", d_rdata, 32'hAAAA5555);
    mem.m_data_ok = 1'b0; d_req = 1'b0; d_wr = 1'b0; d_wen = '0;
    step();
    chk("wr_d_done_pulse", {31'd0, d_done}, 32'd0);

    // Flush before address accept
    i_req = 1'b1; i_addr = 32'h00002000;
    step();
    chk("fa_m_req", {31'd0, mem.m_req}, 32'd1);
    flush = 1'b1;
    step();
    chk("fa_m_req_drop", {31'd0, mem.m_req}, 32'd0);
    chk("fa_busy", {31'd0, busy}, 32'd0);
    chk("fa_no_done", {31'd0, i_done}, 32'd0);
    flush = 1'b0; i_req = 1'b0;
    step();
    chk("fa_still_idle", {31'd0, busy}, 32'd0);
    chk("fa_no_done_late", {31'd0, i_done}, 32'd0);

    // Flush after address accept: completes silently
    i_req = 1'b1; i_addr = 32'h00003000;
    step();
    mem.m_addr_ok = 1'b1;
    step();
    mem.m_addr_ok = 1'b0; flush = 1'b1;
    step();
    chk("fd_busy_data", {31'd0, busy}, 32'd1);
    flush = 1'b0; i_req = 1'b0;
    mem.m_data_ok = 1'b1; mem.m_rdata = 32'h12345678;
    step();
    chk("fd_no_done", {31'd0, i_done}, 32'd0);
    chk("fd_i_rdata_kept", i_rdata, 32'h11112222);
    chk("fd_idle", {31'd0, busy}, 32'd0);
    mem.m_data_ok = 1'b0;
    i_req = 1'b1; i_addr = 32'h00004000;
    step();
    chk("fd_next_addr", mem.m_addr, 32'h00004000);
    mem.m_addr_ok = 1'b1;
    step();
    mem.m_addr_ok = 1'b0; mem.m_data_ok = 1'b1; mem.m_rdata = 32'hCAFEF00D;
    step();
    chk("fd_next_done", {31'd0, i_done}, 32'd1);
    chk("fd_next_rdata", i_rdata, 32'hCAFEF00D);
    mem.m_data_ok = 1'b0; i_req = 1'b0;
    step();

    // Slave stalls address phase, then async reset mid-DATA
    d_req = 1'b1; d_addr = 32'h00005000;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("st_m_req", {31'd0, mem.m_req}, 32'd1);
      chk("st_m_addr", mem.m_addr, 32'h00005000);
      step();
    end
    mem.m_addr_ok = 1'b1;
    step();
    chk("st_m_req_drop", {31'd0, mem.m_req}, 32'd0);
    mem.m_addr_ok = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_m_addr", mem.m_addr, 32'd0);
    chk("ar_i_rdata", i_rdata, 32'd0);
    chk("ar_d_rdata", d_rdata, 32'd0);
    chk("ar_d_done", {31'd0, d_done}, 32'd0);
    d_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("ar_after_busy", {31'd0, busy}, 32'd0);
    chk("ar_after_d_done", {31'd0, d_done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
